// File: rtl/control_sequencer.sv
// Eight-phase fetch/decode/execute controller for the 8-bit RISC CPU.
// Strobes are a combinational decode of the state register, opcode and zero flag.
module control_sequencer #(
  parameter int unsigned OP_WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_WIDTH-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr,
  output logic [2:0]          phase
);

  typedef enum logic [3:0] {
    StInstAddr  = 4'd0,
    StInstFetch = 4'd1,
    StInstLoad  = 4'd2,
    StIdle      = 4'd3,
    StOpAddr    = 4'd4,
    StOpFetch   = 4'd5,
    StAluOp     = 4'd6,
    StStore     = 4'd7,
    StHalted    = 4'd8
  } state_e;

  localparam logic [OP_WIDTH-1:0] OpHlt = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OpSkz = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OpAdd = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OpAnd = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OpXor = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OpLda = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OpSto = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OpJmp = OP_WIDTH'(7);

  state_e r_state;
  logic   w_aluop;
  logic   w_is_hlt;
  logic   w_is_sto;
  logic   w_is_jmp;

  assign w_aluop  = (opcode == OpAdd) || (opcode == OpAnd) || (opcode == OpXor) ||
                    (opcode == OpLda);
  assign w_is_hlt = (opcode == OpHlt);
  assign w_is_sto = (opcode == OpSto);
  assign w_is_jmp = (opcode == OpJmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInstAddr;
    end else begin
      case (r_state)
        StInstAddr:  r_state <= StInstFetch;
        StInstFetch: r_state <= StInstLoad;
        StInstLoad:  r_state <= StIdle;
        StIdle:      r_state <= StOpAddr;
        StOpAddr:    r_state <= w_is_hlt ? StHalted : StOpFetch;
        StOpFetch:   r_state <= StAluOp;
        StAluOp:     r_state <= StStore;
        StStore:     r_state <= StInstAddr;
        StHalted:    r_state <= StHalted;
        // Corrupted or X encodings restart the instruction cycle.
        default:     r_state <= StInstAddr;
      endcase
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    phase  = 3'd0;
    case (r_state)
      StInstAddr: begin
        sel   = 1'b1;
        phase = 3'd0;
      end
      StInstFetch: begin
        sel   = 1'b1;
        rd    = 1'b1;
        phase = 3'd1;
      end
      StInstLoad, StIdle: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
        phase = (r_state == StIdle) ? 3'd3 : 3'd2;
      end
      StOpAddr: begin
        inc_pc = 1'b1;
        halt   = w_is_hlt;
        phase  = 3'd4;
      end
      StOpFetch: begin
        rd    = w_aluop;
        phase = 3'd5;
      end
      StAluOp: begin
        rd     = w_aluop;
        inc_pc = (opcode == OpSkz) && zero;
        ld_pc  = w_is_jmp;
        data_e = w_is_sto;
        phase  = 3'd6;
      end
      StStore: begin
        rd     = w_aluop;
        ld_ac  = w_aluop;
        ld_pc  = w_is_jmp;
        inc_pc = w_is_jmp;
        wr     = w_is_sto;
        data_e = w_is_sto;
        phase  = 3'd7;
      end
      StHalted: begin
        halt  = 1'b1;
        phase = 3'd4;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed per-opcode phase tables plus randomized
// instruction streams scored against a per-signal behavioural model.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase;
  logic [8:0] w_out;

  int n_vec = 0;
  int n_err = 0;
  int m_phase = 0;
  bit m_halted = 1'b0;

  control_sequencer #(.OP_WIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // Bit order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign w_out = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  // Each strobe written as its own rule over phase number and opcode class.
  function automatic logic [8:0] model_out(int ph, bit hl, logic [2:0] op, logic z);
    bit aluop;
    logic s_sel, s_rd, s_ir, s_inc, s_hlt, s_lpc, s_de, s_lac, s_wr;
    if (hl) return 9'h010;
    aluop = (op >= 3'd2) && (op <= 3'd5);
    s_sel = (ph <= 3);
    s_rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    s_ir  = (ph == 2) || (ph == 3);
    s_inc = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    s_hlt = (ph == 4) && (op == 3'd0);
    s_lpc = (ph >= 6) && (op == 3'd7);
    s_de  = (ph >= 6) && (op == 3'd6);
    s_lac = (ph == 7) && aluop;
    s_wr  = (ph == 7) && (op == 3'd6);
    return {s_sel, s_rd, s_ir, s_inc, s_hlt, s_lpc, s_de, s_lac, s_wr};
  endfunction

  // Advance the reference across one rising edge, using inputs held before it.
  task automatic step();
    if (!rst) begin
      if (m_halted) m_halted = 1'b1;
      else if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
      else m_phase = (m_phase + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 3'd2; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (w_out !== 9'h100 || phase !== 3'd0) begin
      n_err++;
      $display("FAIL reset_hold: got %h/%0d want 100/0", w_out, phase);
    end
    rst = 1'b0; m_phase = 0; m_halted = 1'b0;
    repeat (5) step();
    n_vec++;
    if (phase !== 3'd5) begin
      n_err++;
      $display("FAIL reset_reach5: got phase %0d want 5", phase);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (w_out !== 9'h100 || phase !== 3'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h/%0d want 100/0", w_out, phase);
    end
    @(posedge clk);
    #1 rst = 1'b0; m_phase = 0; m_halted = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_vec++;
      if (phase !== 3'(i % 8)) begin
        n_err++;
        $display("FAIL reset_seq: got phase %0d want %0d", phase, i % 8);
      end
    end
  endtask

  task automatic test_add();
    logic [8:0] tbl [8];
    tbl = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h080, 9'h080, 9'h082};
    for (int ph = 0; ph < 8; ph++) begin
      opcode = (ph < 3) ? 3'($urandom) : 3'd2;
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (w_out !== tbl[ph] || phase !== 3'(ph)) begin
        n_err++;
        $display("FAIL add: ph%0d got %h/%0d want %h/%0d", ph, w_out, phase, tbl[ph], ph);
      end
      step();
    end
  endtask

  task automatic test_sto();
    logic [8:0] tbl [8];
    tbl = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h004, 9'h005};
    for (int ph = 0; ph < 8; ph++) begin
      opcode = (ph < 3) ? 3'($urandom) : 3'd6;
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (w_out !== tbl[ph] || phase !== 3'(ph)) begin
        n_err++;
        $display("FAIL sto: ph%0d got %h/%0d want %h/%0d", ph, w_out, phase, tbl[ph], ph);
      end
      step();
    end
  endtask

  task automatic test_jmp();
    logic [8:0] tbl [8];
    tbl = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h008, 9'h028};
    for (int ph = 0; ph < 8; ph++) begin
      opcode = (ph < 3) ? 3'($urandom) : 3'd7;
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (w_out !== tbl[ph] || phase !== 3'(ph)) begin
        n_err++;
        $display("FAIL jmp: ph%0d got %h/%0d want %h/%0d", ph, w_out, phase, tbl[ph], ph);
      end
      step();
    end
  endtask

  // Zero is forced at phase 6 and driven opposite in phases 5 and 7.
  task automatic test_skz();
    logic [8:0] tbl [8];
    logic [8:0] exp;
    for (int z = 1; z >= 0; z--) begin
      tbl = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h020, 9'h000, 9'h000, 9'h000};
      for (int ph = 0; ph < 8; ph++) begin
        opcode = (ph < 3) ? 3'($urandom) : 3'd1;
        if (ph == 6) zero = 1'(z);
        else if (ph == 5 || ph == 7) zero = 1'(1 - z);
        else zero = 1'($urandom);
        #1;
        exp = (ph == 6 && z == 1) ? 9'h020 : tbl[ph];
        n_vec++;
        if (w_out !== exp || phase !== 3'(ph)) begin
          n_err++;
          $display("FAIL skz_z%0d: ph%0d got %h/%0d want %h/%0d", z, ph, w_out, phase, exp, ph);
        end
        step();
      end
    end
  endtask

  task automatic test_hlt();
    logic [8:0] tbl [5];
    tbl = '{9'h100, 9'h180, 9'h1C0, 9'h1C0, 9'h030};
    for (int ph = 0; ph < 5; ph++) begin
      opcode = (ph < 3) ? 3'($urandom) : 3'd0;
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (w_out !== tbl[ph] || phase !== 3'(ph)) begin
        n_err++;
        $display("FAIL hlt: ph%0d got %h/%0d want %h/%0d", ph, w_out, phase, tbl[ph], ph);
      end
      step();
    end
    for (int i = 0; i < 24; i++) begin
      opcode = 3'($urandom);
      zero   = 1'($urandom);
      #1;
      n_vec++;
      if (w_out !== 9'h010 || phase !== 3'd4) begin
        n_err++;
        $display("FAIL halted: cyc%0d got %h/%0d want 010/4", i, w_out, phase);
      end
      step();
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (w_out !== 9'h100 || phase !== 3'd0) begin
      n_err++;
      $display("FAIL halt_reset: got %h/%0d want 100/0", w_out, phase);
    end
    @(posedge clk);
    #1 rst = 1'b0; m_phase = 0; m_halted = 1'b0;
  endtask

  // Random back-to-back instructions; halts are cleared by an async reset.
  task automatic test_random();
    logic [8:0] exp;
    int halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      opcode = 3'($urandom_range(0, 7));
      if (opcode == 3'd0 && $urandom_range(0, 3) != 0) opcode = 3'd4;
      zero = 1'($urandom);
      #1;
      exp = model_out(m_phase, m_halted, opcode, zero);
      n_vec++;
      if (w_out !== exp || phase !== 3'(m_halted ? 4 : m_phase)) begin
        n_err++;
        $display("FAIL random: cyc%0d op%0d z%0d got %h/%0d want %h/%0d", i, opcode, zero,
                 w_out, phase, exp, m_halted ? 4 : m_phase);
      end
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 3 || (m_phase == 6 && $urandom_range(0, 19) == 0)) begin
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (w_out !== 9'h100 || phase !== 3'd0) begin
          n_err++;
          $display("FAIL random_reset: cyc%0d got %h/%0d want 100/0", i, w_out, phase);
        end
        @(posedge clk);
        #1 rst = 1'b0; m_phase = 0; m_halted = 1'b0; halted_cycles = 0;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sto();
    test_jmp();
    test_skz();
    test_hlt();
    test_add();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
